servo_pwm_bank: RTL

//  Parametrised bank of NUM_CH hobby-servo PWM generators sharing one frame counter.
//  Per-channel angle commands are clamped, double-buffered and applied only at frame boundaries, so no runt or stretched pulses occur.

---
 rtl/servo_pkg.sv | 25 ++
 rtl/servo_pwm_ch.sv | 88 ++++++++
 rtl/servo_pwm_bank.sv | 91 +++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared defaults and helpers for the servo PWM bank: timing constants,
// frame-counter width derivation and the angle-to-pulse-width mapping.
package servo_pkg;

   localparam int unsigned SERVO_NUM_CH     = 3;
   localparam int unsigned SERVO_ANGLE_W    = 8;
   localparam int unsigned SERVO_ANGLE_MAX  = 180;
   localparam int unsigned SERVO_ANGLE_RST  = 90;
   localparam int unsigned SERVO_PERIOD_CYC = 1000000;
   localparam int unsigned SERVO_PULSE_MIN  = 50000;
   localparam int unsigned SERVO_PULSE_STEP = 278;
   localparam int unsigned SERVO_SLEW_STEP  = 4;

   // One spare bit so pulse widths up to the full period compare without wrap.
   function automatic int unsigned cnt_width(input int unsigned period);
      return unsigned'($clog2(period)) + 1;
   endfunction

   function automatic int unsigned angle_to_cycles(input int unsigned angle,
                                                   input int unsigned pulse_min,
                                                   input int unsigned pulse_step);
      return pulse_min + angle * pulse_step;
   endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo channel: clamped target register, frame-boundary angle update and
// pulse generation. Define SERVO_SLEW_EN to rate-limit angle changes per frame.
module servo_pwm_ch
   import servo_pkg::*;
#(
   parameter int unsigned ANGLE_W    = SERVO_ANGLE_W,
   parameter int unsigned ANGLE_MAX  = SERVO_ANGLE_MAX,
   parameter int unsigned ANGLE_RST  = SERVO_ANGLE_RST,
   parameter int unsigned PULSE_MIN  = SERVO_PULSE_MIN,
   parameter int unsigned PULSE_STEP = SERVO_PULSE_STEP,
   parameter int unsigned CNT_W      = 21
`ifdef SERVO_SLEW_EN
   ,
   parameter int unsigned SLEW_STEP  = SERVO_SLEW_STEP
`endif
) (
   input  logic               clk_i,
   input  logic               srst_i,
   input  logic               frame_start_i,
   input  logic [CNT_W-1:0]   cnt_next_i,
   input  logic               en_i,
   input  logic               wr_i,
   input  logic [ANGLE_W-1:0] angle_i,
   output logic               pwm_o,
   output logic [ANGLE_W-1:0] cur_o,
   output logic               settled_o
);

   localparam logic [ANGLE_W-1:0] AMAX_C = ANGLE_W'(ANGLE_MAX);
   localparam logic [ANGLE_W-1:0] ARST_C = ANGLE_W'(ANGLE_RST);

   logic [ANGLE_W-1:0] target_q, target_d;
   logic [ANGLE_W-1:0] cur_q, cur_d;
   logic [ANGLE_W-1:0] slewed;
   logic               en_q, en_d;
   logic               pwm_q, pwm_d;
   logic [CNT_W-1:0]   pulse_cyc;

   always_comb begin
      target_d = target_q;
      if (wr_i) begin
         target_d = (angle_i > AMAX_C) ? AMAX_C : angle_i;
      end
   end

`ifdef SERVO_SLEW_EN
   localparam logic [ANGLE_W-1:0] SLEW_C = ANGLE_W'(SLEW_STEP);

   always_comb begin
      slewed = target_q;
      if (target_q > cur_q) begin
         if (target_q - cur_q > SLEW_C) slewed = cur_q + SLEW_C;
      end else if (cur_q - target_q > SLEW_C) begin
         slewed = cur_q - SLEW_C;
      end
   end
`else
   assign slewed = target_q;
`endif

   // The pulse is decided from next-state values so the registered output
   // rises in the same cycle the registered frame_tick does.
   always_comb begin
      en_d      = frame_start_i ? en_i   : en_q;
      cur_d     = frame_start_i ? slewed : cur_q;
      pulse_cyc = CNT_W'(angle_to_cycles(32'(cur_d), PULSE_MIN, PULSE_STEP));
      pwm_d     = en_d && (cnt_next_i < pulse_cyc);
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         target_q <= ARST_C;
         cur_q    <= ARST_C;
         en_q     <= 1'b0;
         pwm_q    <= 1'b0;
      end else begin
         target_q <= target_d;
         cur_q    <= cur_d;
         en_q     <= en_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o     = pwm_q;
   assign cur_o     = cur_q;
   assign settled_o = (cur_q == target_q);

endmodule

// File: rtl/servo_pwm_bank.sv
// Bank of servo PWM channels sharing one frame counter and frame_tick.
// Define SERVO_SLEW_EN to enable per-frame slew limiting in every channel.
module servo_pwm_bank
   import servo_pkg::*;
#(
   parameter int unsigned NUM_CH     = SERVO_NUM_CH,
   parameter int unsigned ANGLE_W    = SERVO_ANGLE_W,
   parameter int unsigned ANGLE_MAX  = SERVO_ANGLE_MAX,
   parameter int unsigned ANGLE_RST  = SERVO_ANGLE_RST,
   parameter int unsigned PERIOD_CYC = SERVO_PERIOD_CYC,
   parameter int unsigned PULSE_MIN  = SERVO_PULSE_MIN,
   parameter int unsigned PULSE_STEP = SERVO_PULSE_STEP,
   parameter int unsigned SLEW_STEP  = SERVO_SLEW_STEP
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         ch_en,
   input  logic [NUM_CH-1:0]         angle_wr,
   input  logic [NUM_CH*ANGLE_W-1:0] angle_in,
   output logic [NUM_CH-1:0]         pwm_out,
   output logic                      frame_tick,
   output logic [NUM_CH-1:0]         settled,
   output logic [NUM_CH*ANGLE_W-1:0] cur_angle
);

   localparam int unsigned      CNT_W  = cnt_width(PERIOD_CYC);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(PERIOD_CYC - 1);

   if (angle_to_cycles(ANGLE_MAX, PULSE_MIN, PULSE_STEP) >= PERIOD_CYC) begin : g_chk_pulse
      $fatal(1, "servo_pwm_bank: longest pulse does not fit inside the frame");
   end
   if (ANGLE_RST > ANGLE_MAX) begin : g_chk_rst
      $fatal(1, "servo_pwm_bank: reset angle exceeds clamp ceiling");
   end
   if (ANGLE_MAX >= (2 ** ANGLE_W) || SLEW_STEP >= (2 ** ANGLE_W)) begin : g_chk_width
      $fatal(1, "servo_pwm_bank: angle constants do not fit ANGLE_W");
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             run_q;
   logic             tick_q;
   logic             frame_start;

   // The first edge after reset is treated as a boundary so the first frame
   // (and its tick) begins one cycle after release.
   always_comb begin
      frame_start = !run_q || (cnt_q == LAST_C);
      cnt_d       = frame_start ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q  <= '0;
         run_q  <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         run_q  <= 1'b1;
         tick_q <= frame_start;
      end
   end

   assign frame_tick = tick_q;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      servo_pwm_ch #(
         .ANGLE_W    (ANGLE_W),
         .ANGLE_MAX  (ANGLE_MAX),
         .ANGLE_RST  (ANGLE_RST),
         .PULSE_MIN  (PULSE_MIN),
         .PULSE_STEP (PULSE_STEP),
         .CNT_W      (CNT_W)
`ifdef SERVO_SLEW_EN
         ,
         .SLEW_STEP  (SLEW_STEP)
`endif
      ) u_ch (
         .clk_i         (clock),
         .srst_i        (reset),
         .frame_start_i (frame_start),
         .cnt_next_i    (cnt_d),
         .en_i          (ch_en[gi]),
         .wr_i          (angle_wr[gi]),
         .angle_i       (angle_in[gi*ANGLE_W +: ANGLE_W]),
         .pwm_o         (pwm_out[gi]),
         .cur_o         (cur_angle[gi*ANGLE_W +: ANGLE_W]),
         .settled_o     (settled[gi])
      );
   end

endmodule
